// File: rtl/tiger_muldiv.sv
// tiger_muldiv: iterative HI/LO multiply/divide unit.
// Define TIGER_MULDIV_FASTMUL_EN for a single-cycle multiplier path.
module tiger_muldiv #(
  parameter logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  logic        is_div;
  logic [5:0]  cnt;
  logic [31:0] ma;
  logic [31:0] mb;
  logic        nega;
  logic        negb;
  logic [63:0] acc;

  logic        sa_in;
  logic        sb_in;
  logic [31:0] ma_in;
  logic [31:0] mb_in;

  logic [32:0] mul_sum;
  logic [32:0] div_sub;
  logic [63:0] acc_nxt;

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] araw;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // operand magnitudes and signs as seen at the accept edge
  always_comb begin
    sa_in = ~op[0] & srca[31];
    sb_in = ~op[0] & srcb[31];
    ma_in = sa_in ? -srca : srca;
    mb_in = sb_in ? -srcb : srcb;
  end

  // one shift-add or restoring shift-subtract step
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
    div_sub = acc[63:31] - {1'b0, mb};
    acc_nxt = acc;
    if (!is_div)
      acc_nxt = {mul_sum, acc[31:1]};
    else if (!div_sub[32])
      acc_nxt = {div_sub[31:0], acc[30:0], 1'b1};
    else
      acc_nxt = {acc[62:0], 1'b0};
  end

  // sign correction and divide-by-zero override for the FIN write
  always_comb begin
    prod = (nega ^ negb) ? -acc : acc;
    quo  = (nega ^ negb) ? -acc[31:0] : acc[31:0];
    rem  = nega ? -acc[63:32] : acc[63:32];
    araw = nega ? -ma : ma;
    if (!is_div) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (mb == 32'd0) begin
      res_hi = araw;
      res_lo = DIVZERO_LO;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  assign busy = (state != IDLE);

  // control FSM, datapath registers and architectural HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      is_div <= 1'b0;
      cnt    <= 6'd0;
      ma     <= 32'd0;
      mb     <= 32'd0;
      nega   <= 1'b0;
      negb   <= 1'b0;
      acc    <= 64'd0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            is_div <= op[1];
            ma     <= ma_in;
            mb     <= mb_in;
            nega   <= sa_in;
            negb   <= sb_in;
            cnt    <= 6'd32;
            acc    <= {32'd0, op[1] ? ma_in : mb_in};
            state  <= BUSY;
`ifdef TIGER_MULDIV_FASTMUL_EN
            if (!op[1]) begin
              acc   <= {32'd0, ma_in} * {32'd0, mb_in};
              cnt   <= 6'd0;
              state <= FIN;
            end
`endif
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= FIN;
        end
        FIN: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
